// File: rtl/ni_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// ni_packetizer_pkg
// Shared definitions for the network-interface packetizer:
//   - flit width and router address width (from `DATA_WIDTH / `AXIS)
//   - flit type codes and field offsets inside a flit
//   - NI FSM state encoding
//   - helper that assembles the upper 31 bits of a header flit
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef AXIS
`define AXIS 4
`endif

package ni_packetizer_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int AXIS       = `AXIS;
  localparam int LEN_W      = 12;
  localparam int SEQ_W      = 8;
  localparam int WORD_W     = 28;

  // Flit type codes, one-hot so a single bit identifies the flit kind
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  // Field offsets (LSB position) inside a flit
  localparam int TYPE_LSB = 29;
  localparam int LEN_LSB  = 17;
  localparam int DST_LSB  = 13;
  localparam int SRC_LSB  = 9;
  localparam int SEQ_LSB  = 1;
  localparam int PAR_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } ni_state_e;

  // Bits [31:1] of a header flit; parity is appended by the output register
  function automatic logic [DATA_WIDTH-2:0] make_header(
    input logic [LEN_W-1:0] len,
    input logic [AXIS-1:0]  dst,
    input logic [AXIS-1:0]  src,
    input logic [SEQ_W-1:0] seq
  );
    return {FLIT_HEADER, len, dst, src, seq};
  endfunction

  // Bits [31:1] of a body or tail flit
  function automatic logic [DATA_WIDTH-2:0] make_data(
    input logic [2:0]        ftype,
    input logic [WORD_W-1:0] word
  );
    return {ftype, word};
  endfunction

endpackage

// File: rtl/ni_packetizer_out_reg.sv
// ---------------------------------------------------------------------------
// ni_out_reg
// Single-flit output register in front of the router LOCAL port.
// Holds one flit plus a valid bit; the flit leaves when the router can take
// it (rts_o = valid & dcts_i). A new flit may be loaded in the same cycle
// the current one drains, so back-to-back flits need no bubble.
// Optional feature macro: NI_PARITY_EN -> bit[0] is even parity over [31:1];
// otherwise bit[0] is 0.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         write flit_i into the register this cycle
//   flit_i         bits [31:1] of the flit to load
//   dcts_i         router can accept a flit
//   valid_o        register holds a flit
//   data_o         registered flit (stable while valid_o & !dcts_i)
//   rts_o          transfer strobe, flit leaves this cycle
// ---------------------------------------------------------------------------
module ni_out_reg
  import ni_packetizer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-2:0] flit_i,
  input  logic                  dcts_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rts_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity;

  // Parity is computed at load time so the registered flit is complete
  always_comb begin
`ifdef NI_PARITY_EN
    parity = ^flit_i;
`else
    parity = 1'b0;
`endif
  end

  // Load wins over drain: a same-cycle load replaces the departing flit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= {flit_i, parity};
    end else if (rts_o) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign rts_o   = valid_q & dcts_i;

endmodule

// File: rtl/ni_packetizer.sv
// ---------------------------------------------------------------------------
// ni_packetizer
// Network-interface injector for the router LOCAL input port. Accepts a
// packet descriptor (destination, payload length P) and P payload words,
// and emits header, P-1 body flits and one tail flit under RTS/CTS flow
// control, at most one flit per cycle.
// Optional feature macro: NI_PARITY_EN (even parity in flit bit[0]).
// Parameters: CUR_ADDR - source router address written into headers.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   pkt_valid/pkt_ready  descriptor handshake; pkt_dst, pkt_len (1..4094)
//   wr_valid/wr_ready    payload word handshake; wr_data (28 bits)
//   tx_data, tx_rts      flit and transfer strobe to router L_RX/L_DRTS
//   tx_dcts              router L_CTS
//   busy                 packet in progress (accept .. tail transfer)
//   err_len              one-cycle pulse when an illegal length is dropped
// ---------------------------------------------------------------------------
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter logic [AXIS-1:0] CUR_ADDR = 4'b0010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [AXIS-1:0]       pkt_dst,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_W-1:0]     wr_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_rts,
  input  logic                  tx_dcts,
  output logic                  busy,
  output logic                  err_len
);

  ni_state_e             state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic                  pkt_ready_q;
  logic                  busy_q;
  logic                  err_len_q, err_len_d;

  logic                  out_valid;
  logic                  load;
  logic [DATA_WIDTH-2:0] load_flit;
  logic                  pkt_fire;
  logic                  wr_fire;
  logic                  len_ok;

  // Lengths 0 and 4095 cannot be encoded (header carries P+1 in 12 bits)
  assign len_ok   = (pkt_len != '0) && (pkt_len != {LEN_W{1'b1}});
  assign pkt_fire = pkt_valid & pkt_ready_q;

  // A word is only taken when the output register has room this cycle
  assign wr_ready = (state_q == ST_PAYLOAD) & (~out_valid | tx_rts);
  assign wr_fire  = wr_valid & wr_ready;

  // Next-state and flit selection. The last payload word always becomes
  // the tail, so a one-word packet is header + tail with no body.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    seq_d     = seq_q;
    err_len_d = 1'b0;
    load      = 1'b0;
    load_flit = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pkt_fire) begin
          if (len_ok) begin
            load      = 1'b1;
            load_flit = make_header(LEN_W'(pkt_len + 12'd1), pkt_dst, CUR_ADDR, seq_q);
            rem_d     = pkt_len;
            state_d   = ST_PAYLOAD;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (wr_fire) begin
          load  = 1'b1;
          rem_d = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            load_flit = make_data(FLIT_TAIL, wr_data);
            state_d   = ST_DRAIN;
          end else begin
            load_flit = make_data(FLIT_BODY, wr_data);
          end
        end
      end
      ST_DRAIN: begin
        if (tx_rts) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered handshake/status outputs, derived from the next
  // state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      seq_q       <= '0;
      pkt_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      seq_q       <= seq_d;
      pkt_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      err_len_q   <= err_len_d;
    end
  end

  ni_out_reg u_out_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .flit_i  (load_flit),
    .dcts_i  (tx_dcts),
    .valid_o (out_valid),
    .data_o  (tx_data),
    .rts_o   (tx_rts)
  );

  assign pkt_ready = pkt_ready_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// ---------------------------------------------------------------------------
// tb_ni_packetizer
// Self-checking bench for ni_packetizer: a cycle-by-cycle vector table for
// the single-packet scenarios, plus hand-written sequences for the sequence
// number wrap and mid-packet reset. Build with +define+NI_PARITY_EN to get
// parity in the expected flits.
// ---------------------------------------------------------------------------
module tb_ni_packetizer;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dst;
  logic [11:0] pkt_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [27:0] wr_data;
  logic [31:0] tx_data;
  logic        tx_rts;
  logic        tx_dcts;
  logic        busy;
  logic        err_len;

  int total;
  int bad;

  typedef struct {
    logic        pv;
    logic [11:0] len;
    logic [3:0]  dst;
    logic        wv;
    logic [27:0] wd;
    logic        dcts;
    logic        eRts;
    logic        eChk;
    logic [31:0] eData;
    logic        eWr;
    logic        ePk;
    logic        eBusy;
    logic        eErr;
  } vec_t;

  vec_t vecs[$];

  ni_packetizer dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dst   (pkt_dst),
    .pkt_len   (pkt_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .tx_data   (tx_data),
    .tx_rts    (tx_rts),
    .tx_dcts   (tx_dcts),
    .busy      (busy),
    .err_len   (err_len)
  );

  // 10-unit clock; inputs change on the falling edge, outputs are checked
  // two units later, well away from the rising edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference flit builder, independent of the RTL package
  function automatic logic [31:0] flit(input logic [2:0] t, input logic [27:0] p);
    logic [30:0] b;
    logic        par;
    b = {t, p};
`ifdef NI_PARITY_EN
    par = ^b;
`else
    par = 1'b0;
`endif
    return {b, par};
  endfunction

  function automatic logic [31:0] hdr(input logic [11:0] l, input logic [3:0] d, input logic [7:0] s);
    return flit(3'b001, {l, d, 4'b0010, s});
  endfunction

  function automatic logic [31:0] bd(input logic [27:0] w);
    return flit(3'b010, w);
  endfunction

  function automatic logic [31:0] tl(input logic [27:0] w);
    return flit(3'b100, w);
  endfunction

  function automatic vec_t mk(
    input logic pv, input logic [11:0] len, input logic [3:0] dst,
    input logic wv, input logic [27:0] wd, input logic dcts,
    input logic eRts, input logic eChk, input logic [31:0] eData,
    input logic eWr, input logic ePk, input logic eBusy, input logic eErr
  );
    vec_t v;
    v.pv = pv; v.len = len; v.dst = dst; v.wv = wv; v.wd = wd; v.dcts = dcts;
    v.eRts = eRts; v.eChk = eChk; v.eData = eData;
    v.eWr = eWr; v.ePk = ePk; v.eBusy = eBusy; v.eErr = eErr;
    return v;
  endfunction

  // Single comparison: counts it and reports a mismatch
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    pkt_valid = v.pv;
    pkt_len   = v.len;
    pkt_dst   = v.dst;
    wr_valid  = v.wv;
    wr_data   = v.wd;
    tx_dcts   = v.dcts;
  endtask

  // Compare all outputs of the current cycle against the record
  task automatic checkOutput(input vec_t v, input int idx);
    #2;
    check($sformatf("v%0d tx_rts", idx), {31'd0, tx_rts}, {31'd0, v.eRts});
    if (v.eChk) check($sformatf("v%0d tx_data", idx), tx_data, v.eData);
    check($sformatf("v%0d wr_ready", idx), {31'd0, wr_ready}, {31'd0, v.eWr});
    check($sformatf("v%0d pkt_ready", idx), {31'd0, pkt_ready}, {31'd0, v.ePk});
    check($sformatf("v%0d busy", idx), {31'd0, busy}, {31'd0, v.eBusy});
    check($sformatf("v%0d err_len", idx), {31'd0, err_len}, {31'd0, v.eErr});
  endtask

  // Everything must read zero while reset is held
  task automatic checkResetOutputs(input string tag);
    check({tag, " tx_rts"}, {31'd0, tx_rts}, 32'd0);
    check({tag, " tx_data"}, tx_data, 32'd0);
    check({tag, " pkt_ready"}, {31'd0, pkt_ready}, 32'd0);
    check({tag, " wr_ready"}, {31'd0, wr_ready}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " err_len"}, {31'd0, err_len}, 32'd0);
  endtask

  // One-word packet sent back-to-back: accept, header, tail (3 cycles)
  task automatic sendP1(input logic [3:0] d, input logic [27:0] w, input logic [7:0] s, input int n);
    @(negedge clk);
    pkt_valid = 1'b1; pkt_len = 12'd1; pkt_dst = d; wr_valid = 1'b0; tx_dcts = 1'b1;
    #2 check($sformatf("p%0d pkt_ready", n), {31'd0, pkt_ready}, 32'd1);
    @(negedge clk);
    pkt_valid = 1'b0; wr_valid = 1'b1; wr_data = w;
    #2;
    check($sformatf("p%0d hdr rts", n), {31'd0, tx_rts}, 32'd1);
    check($sformatf("p%0d hdr", n), tx_data, hdr(12'd2, d, s));
    @(negedge clk);
    wr_valid = 1'b0;
    #2 check($sformatf("p%0d tail", n), tx_data, tl(w));
  endtask

  // Hang guard
  initial begin
    #300000;
    $display("[TB] FAIL timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [27:0] wA, wB, wC, wD, wE, wF, wG, w1, w2;
    total = 0;
    bad   = 0;
    wA = 28'hAAA_0001; wB = 28'hBBB_0002; wC = 28'hCCC_0003; wD = 28'hDDD_0004;
    wE = 28'h123_4567; wF = 28'h765_4321; wG = 28'hFFF_FFFF;
    w1 = 28'h5A5_A5A5; w2 = 28'h000_0001;

    // Vector table: one record per clock cycle
    // P=1, dst=1, seq 0
    vecs.push_back(mk(1, 12'd1, 4'd1, 0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, w1, 1, 1, 1, hdr(12'd2, 4'd1, 8'd0), 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 1, tl(w1),            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    // P=4, dst=5, seq 1: five consecutive flits
    vecs.push_back(mk(1, 12'd4, 4'd5, 0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, wA, 1, 1, 1, hdr(12'd5, 4'd5, 8'd1), 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wB, 1, 1, 1, bd(wA),            1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wC, 1, 1, 1, bd(wB),            1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wD, 1, 1, 1, bd(wC),            1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 1, tl(wD),            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    // P=3, dst=3, seq 2: router stalls three cycles with the header held
    vecs.push_back(mk(1, 12'd3, 4'd3, 0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, wE, 0, 0, 1, hdr(12'd4, 4'd3, 8'd2), 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wE, 0, 0, 1, hdr(12'd4, 4'd3, 8'd2), 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wE, 0, 0, 1, hdr(12'd4, 4'd3, 8'd2), 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wE, 1, 1, 1, hdr(12'd4, 4'd3, 8'd2), 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wF, 1, 1, 1, bd(wE),            1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, wG, 1, 1, 1, bd(wF),            1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 1, tl(wG),            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    // Illegal lengths 0 and 4095: error pulses, no flits
    vecs.push_back(mk(1, 12'd0, 4'd7, 0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    vecs.push_back(mk(1, 12'hFFF, 4'd7, 0, 0, 1, 0, 0, 0,                0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    // Next legal packet still carries seq 3
    vecs.push_back(mk(1, 12'd1, 4'hF, 0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, w2, 1, 1, 1, hdr(12'd2, 4'hF, 8'd3), 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  1, 1, tl(w2),            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1,  0, 0, 0,                 0, 1, 0, 0));

    // Power-up reset
    rst = 1'b1; pkt_valid = 1'b0; pkt_len = '0; pkt_dst = '0;
    wr_valid = 1'b0; wr_data = '0; tx_dcts = 1'b1;
    @(negedge clk);
    #2 checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Fresh reset, then 257 back-to-back one-word packets: seq wraps to 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 257; n++) begin
      sendP1(4'(n), 28'(n * 3 + 1), 8'(n), n);
    end

    // Reset in the middle of a body: outputs clear at once, seq restarts
    @(negedge clk);
    pkt_valid = 1'b1; pkt_len = 12'd4; pkt_dst = 4'd9; wr_valid = 1'b0;
    @(negedge clk);
    pkt_valid = 1'b0; wr_valid = 1'b1; wr_data = wA;
    @(negedge clk);
    wr_data = wB;
    #2 check("mid body before rst", tx_data, bd(wA));
    #1 rst = 1'b1;
    #1 checkResetOutputs("mid rst");
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    sendP1(4'd6, wC, 8'd0, 999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
